// File: rtl/strob_sched_pkg.sv
// Shared types and helpers for the round-robin write-strobe scheduler.
package strob_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned GAP_W = 4;

  // First set bit of req[n-1:0], scanning upward from start and wrapping at n.
  function automatic int unsigned rr_first(input logic [15:0] req,
                                           input int unsigned n,
                                           input int unsigned start);
    int unsigned sel;
    int unsigned idx;
    logic        found;
    sel   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx = start + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && req[idx[3:0]]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/strob_sync_edge.sv
// One requester: synchroniser chain, delay flop and single-cycle rising-edge pulse.
module strob_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic CLR_n,
  input  logic i_req,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/strob_sched.sv
// Round-robin scheduler: queues edge-detected requests and issues spaced single-cycle strobes.
module strob_sched
  import strob_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                     CLK,
  input  logic                     CLR_n,
  input  logic [N_REQ-1:0]         strob_WR,
  output logic                     strob_main,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [N_REQ-1:0]         pending,
  output logic [N_REQ-1:0]         ovf
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t           r_state, w_next;
  logic [GAP_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDW-1:0]   r_ptr, r_grant, w_win;
  logic [N_REQ-1:0] r_pending, r_ovf, w_clr, w_pulse;
  logic [15:0]      w_req16;
  int unsigned      w_start;
  logic             r_strob, r_busy;

  for (genvar g = 0; g < N_REQ; g++) begin : g_sync
    strob_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLK    (CLK),
      .CLR_n  (CLR_n),
      .i_req  (strob_WR[g]),
      .o_pulse(w_pulse[g])
    );
  end

  always_comb begin
    w_req16              = '0;
    w_req16[N_REQ-1:0]   = r_pending;
    w_start              = (32'(r_ptr) + 32'd1 >= N_REQ) ? 32'd0 : 32'(r_ptr) + 32'd1;
    w_win                = IDW'(rr_first(w_req16, N_REQ, w_start));
    w_next               = r_state;
    w_cnt_nxt            = r_cnt;
    w_clr                = '0;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_next       = ISSUE;
          w_clr[w_win] = 1'b1;
        end
      end
      ISSUE: begin
        w_next    = (GAP_CYCLES > 0) ? GAP : IDLE;
        w_cnt_nxt = GAP_LOAD;
      end
      GAP: begin
        if (r_cnt == '0) w_next = IDLE;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // Strobe and busy are registered from the next state so every output comes straight off a flop.
  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= IDW'(N_REQ - 1);
      r_grant   <= '0;
      r_strob   <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= '0;
      r_ovf     <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_strob <= (w_next == ISSUE);
      r_busy  <= (w_next != IDLE);
      if (r_state == IDLE && |r_pending) begin
        r_grant <= w_win;
        r_ptr   <= w_win;
      end
      // A new pulse wins over a same-edge grant clear and does not count as overflow.
      r_pending <= (r_pending & ~w_clr) | w_pulse;
      r_ovf     <= r_ovf | (w_pulse & r_pending & ~w_clr);
    end
  end

  assign strob_main = r_strob;
  assign grant_id   = r_grant;
  assign busy       = r_busy;
  assign pending    = r_pending;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_strob_sched.sv
// Directed bench for strob_sched: default instance plus a zero-gap instance.
module tb_strob_sched;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       CLR_n;
  logic [3:0] strob_WR;
  logic       strob_main;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] ovf;

  logic       CLR1_n;
  logic [3:0] wr1;
  logic       strob1;
  logic [1:0] grant1;
  logic       busy1;
  logic [3:0] pending1;
  logic [3:0] ovf1;

  int n_checks = 0;
  int n_errors = 0;
  int s_cnt [4] = '{default: 0};
  int c_snap;

  strob_sched dut (
    .CLK       (CLK),
    .CLR_n     (CLR_n),
    .strob_WR  (strob_WR),
    .strob_main(strob_main),
    .grant_id  (grant_id),
    .busy      (busy),
    .pending   (pending),
    .ovf       (ovf)
  );

  strob_sched #(.GAP_CYCLES(0)) dut_nogap (
    .CLK       (CLK),
    .CLR_n     (CLR1_n),
    .strob_WR  (wr1),
    .strob_main(strob1),
    .grant_id  (grant1),
    .busy      (busy1),
    .pending   (pending1),
    .ovf       (ovf1)
  );

  always @(negedge CLK)
    if (CLR_n === 1'b1 && strob_main === 1'b1) s_cnt[grant_id]++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    CLR_n    = 1'b0;
    CLR1_n   = 1'b0;
    strob_WR = 4'hF;
    wr1      = 4'h0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outs", {strob_main, busy, grant_id, pending, ovf}, 32'd0);
      chk("rst_outs_nogap", {strob1, busy1, grant1, pending1, ovf1}, 32'd0);
    end
    CLR_n  = 1'b1;
    CLR1_n = 1'b1;

    for (int e = 0; e < 16; e++) begin
      tick();
      if (e == 1) chk("rst_pend_early", pending, 4'h0);
      if (e == 2) chk("rst_pend_all", pending, 4'hF);
      if (e == 3 || e == 7 || e == 11 || e == 15) begin
        chk("rr_strobe", strob_main, 1);
        chk("rr_grant", grant_id, (e - 3) / 4);
      end else begin
        chk("rr_no_strobe", strob_main, 0);
      end
      if (e == 6) chk("rr_busy_gap_end", busy, 0);
    end
    strob_WR = 4'h0;
    repeat (8) tick();
    chk("rr_ovf_clear", ovf, 4'h0);
    chk("rr_settled", {busy, pending}, 32'd0);

    strob_WR = 4'b0100;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (e == 1) chk("single_pend_lat", pending, 4'h0);
      if (e == 2) chk("single_pend", pending, 4'b0100);
      if (e == 3) begin
        chk("single_strobe", strob_main, 1);
        chk("single_grant", grant_id, 2);
        chk("single_busy", busy, 1);
        chk("single_pend_clr", pending, 4'h0);
      end
      if (e == 4) chk("single_strobe_1cyc", strob_main, 0);
      if (e == 5) chk("single_busy_gap", busy, 1);
      if (e == 6) chk("single_busy_fall", busy, 0);
    end
    strob_WR = 4'h0;
    repeat (6) tick();

    strob_WR = 4'b0010;
    tick();
    strob_WR = 4'b1011;
    for (int e = 1; e < 12; e++) begin
      tick();
      if (e == 3) begin
        chk("fair_strobe1", strob_main, 1);
        chk("fair_grant1", grant_id, 1);
      end
      if (e == 4) chk("fair_pend", pending, 4'b1001);
      if (e == 7) begin
        chk("fair_strobe3", strob_main, 1);
        chk("fair_grant3", grant_id, 3);
      end
      if (e == 11) begin
        chk("fair_strobe0", strob_main, 1);
        chk("fair_grant0", grant_id, 0);
      end
    end
    strob_WR = 4'h0;
    repeat (8) tick();

    c_snap   = s_cnt[1];
    strob_WR = 4'b0100;
    tick();
    strob_WR = 4'b1110;
    tick();
    strob_WR = 4'b1100;
    repeat (3) tick();
    strob_WR = 4'b1110;
    tick();
    strob_WR = 4'h0;
    tick();
    tick();
    chk("ovf_grant3_strobe", strob_main, 1);
    chk("ovf_grant3", grant_id, 3);
    chk("ovf_set", ovf, 4'b0010);
    repeat (3) tick();
    tick();
    chk("ovf_grant1_strobe", strob_main, 1);
    chk("ovf_grant1", grant_id, 1);
    chk("ovf_pend_empty", pending, 4'h0);
    repeat (12) tick();
    chk("ovf_one_strobe", s_cnt[1] - c_snap, 1);
    chk("ovf_sticky", ovf, 4'b0010);

    strob_WR = 4'b1001;
    repeat (4) tick();
    chk("mid_strobe", strob_main, 1);
    chk("mid_grant", grant_id, 3);
    CLR_n    = 1'b0;
    strob_WR = 4'h0;
    tick();
    chk("mid_rst_outs", {strob_main, busy, grant_id, pending, ovf}, 32'd0);
    CLR_n  = 1'b1;
    c_snap = s_cnt[0] + s_cnt[1] + s_cnt[2] + s_cnt[3];
    repeat (20) tick();
    chk("mid_no_strobe", s_cnt[0] + s_cnt[1] + s_cnt[2] + s_cnt[3] - c_snap, 0);
    chk("mid_pend", pending, 4'h0);

    wr1 = 4'b0011;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (e == 3) begin
        chk("nogap_strobe0", strob1, 1);
        chk("nogap_grant0", grant1, 0);
      end
      if (e == 4) begin
        chk("nogap_idle_strobe", strob1, 0);
        chk("nogap_idle_busy", busy1, 0);
      end
      if (e == 5) begin
        chk("nogap_strobe1", strob1, 1);
        chk("nogap_grant1", grant1, 1);
      end
      if (e == 6) chk("nogap_done", strob1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
